// File: rtl/lcg_stim_pkg.sv
// rtl/lcg_stim_pkg.sv - shared constants, enums and LCG step function for the vector source
package lcg_stim_pkg;

  localparam logic [31:0] LCG_A = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_C = 32'h0000_3039;

  // Mode codes 2 and 3 are reserved and decode as LCG.
  typedef enum logic [1:0] {
    MODE_LCG  = 2'd0,
    MODE_WALK = 2'd1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_VALID = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One generator advance: state*A + C, truncated to 32 bits.
  function automatic logic [31:0] lcg_next(input logic [31:0] cur);
    return cur * LCG_A + LCG_C;
  endfunction

endpackage

// File: rtl/lcg32_step.sv
// rtl/lcg32_step.sv - combinational 32-bit LCG multiply-add
module lcg32_step
  import lcg_stim_pkg::*;
(
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  assign nxt = lcg_next(cur);

endmodule

// File: rtl/lcg_vec_source.sv
// rtl/lcg_vec_source.sv - LCG / walking-one stimulus vector source with valid/ready output
module lcg_vec_source
  import lcg_stim_pkg::*;
#(
  parameter int          OUT_W = 133,
  parameter logic [31:0] SEED  = 32'h9B61_D45D,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [31:0]      seed_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] cycles_i,
  output logic [OUT_W-1:0] out_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy,
  output logic             done
);

  // Number of 32-bit draws per vector; the last one is truncated to fit OUT_W.
  localparam int WORDS = (OUT_W + 31) / 32;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int POS_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] VEC_ONE   = OUT_W'(1);
  localparam logic [OUT_W-1:0] WORD_MASK = OUT_W'(32'hFFFF_FFFF);

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cycles_q;
  logic [31:0]      lcg;
  logic [31:0]      lcg_nxt;
  logic [IDX_W-1:0] fill_idx;
  // Bit position of the walking one; tracks vec_count % OUT_W without a divider.
  logic [POS_W-1:0] walk_pos;

  logic             walk_mode;
  logic             fill_last;
  logic             run_last;
  logic [IDX_W+4:0] shamt;
  logic [OUT_W-1:0] fill_vec;

  lcg32_step u_step (
    .cur (lcg),
    .nxt (lcg_nxt)
  );

  assign walk_mode = (mode_q == MODE_WALK);
  assign fill_last = (fill_idx == LAST_IDX);
  assign run_last  = ((vec_count + CNT_W'(1)) == cycles_q);

  // Word k lands at bit 32*k; bits shifted past OUT_W fall off, truncating the last word.
  assign shamt    = {fill_idx, 5'd0};
  assign fill_vec = (out_vec & ~(WORD_MASK << shamt)) | (OUT_W'(lcg_nxt) << shamt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and state-decoded status outputs; abort overrides everything
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = (cycles_i == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (walk_mode || fill_last) begin
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ready) begin
          state_d = run_last ? ST_DONE : ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
    out_valid = (state_q == ST_VALID);
    busy      = (state_q == ST_FILL) || (state_q == ST_VALID);
    done      = (state_q == ST_DONE);
  end

  // Run setup, generator advance, vector assembly and acceptance counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcg       <= SEED;
      out_vec   <= '0;
      vec_count <= '0;
      cycles_q  <= '0;
      mode_q    <= MODE_LCG;
      fill_idx  <= '0;
      walk_pos  <= '0;
    end else if (abort) begin
      // Generator state and count survive an abort so a later run continues the sequence.
      lcg       <= lcg;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_q    <= mode_i;
            cycles_q  <= cycles_i;
            vec_count <= '0;
            fill_idx  <= '0;
            walk_pos  <= '0;
            if (seed_load) begin
              lcg <= seed_i;
            end
          end
        end
        ST_FILL: begin
          if (walk_mode) begin
            out_vec <= VEC_ONE << walk_pos;
          end else begin
            lcg      <= lcg_nxt;
            out_vec  <= fill_vec;
            fill_idx <= fill_last ? '0 : fill_idx + IDX_W'(1);
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            vec_count <= vec_count + CNT_W'(1);
            walk_pos  <= (walk_pos == LAST_POS) ? '0 : walk_pos + POS_W'(1);
          end
        end
        default: begin
          fill_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcg_vec_source.sv
// tb/tb_lcg_vec_source.sv - self-checking bench for lcg_vec_source
module tb_lcg_vec_source;

  localparam int          OUT_W = 40;
  localparam int          CNT_W = 32;
  localparam int          WORDS = (OUT_W + 31) / 32;
  localparam logic [31:0] SEED  = 32'h9B61_D45D;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed_i = '0;
  logic [1:0]       mode_i = '0;
  logic [CNT_W-1:0] cycles_i = '0;
  logic [OUT_W-1:0] out_vec;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] vec_count;
  logic             busy;
  logic             done;

  lcg_vec_source #(
    .OUT_W (OUT_W),
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed_load (seed_load),
    .seed_i    (seed_i),
    .mode_i    (mode_i),
    .cycles_i  (cycles_i),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vec_count (vec_count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, req);
  endtask

  function automatic logic [31:0] f_lcg(input logic [31:0] s);
    return s * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  // Run-level reference model: generator value, accepted count, run status,
  // remaining fill cycles before the next vector, and the vector on display.
  logic [31:0]      m_lcg = SEED;
  logic [31:0]      m_cnt = '0;
  logic [31:0]      m_cycles = '0;
  logic [OUT_W-1:0] m_vec = '0;
  bit               m_busy = 0;
  bit               m_done = 0;
  bit               m_walk = 0;
  bit               m_prev_valid = 0;
  int               m_fill = 0;
  bit               exp_valid;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_lcg = SEED; m_cnt = '0; m_vec = '0;
        m_busy = 0; m_done = 0; m_fill = 0; m_prev_valid = 0;
      end else begin
        check("vec_count", 64'(vec_count), 64'(m_cnt));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        exp_valid = m_busy && (m_fill == 0);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (out_valid && !m_prev_valid) begin
          m_vec = '0;
          if (m_walk) begin
            m_vec = OUT_W'(1) << (m_cnt % 32'(OUT_W));
          end else begin
            for (int k = 0; k < WORDS; k++) begin
              m_lcg = f_lcg(m_lcg);
              m_vec = m_vec | (OUT_W'(m_lcg) << (32 * k));
            end
          end
          check("out_vec", 64'(out_vec), 64'(m_vec));
        end else if (out_valid || m_done) begin
          check("out_vec_hold", 64'(out_vec), 64'(m_vec));
        end
        m_prev_valid = out_valid;

        if (abort) begin
          if (m_busy && m_fill > 0 && !m_walk) begin
            for (int k = 0; k < WORDS - m_fill; k++) m_lcg = f_lcg(m_lcg);
          end
          m_busy = 0; m_done = 0; m_fill = 0;
        end else begin
          if (m_busy && m_fill > 0) m_fill--;
          if (m_busy && out_valid && out_ready) begin
            m_cnt++;
            if (m_cnt == m_cycles) begin
              m_busy = 0; m_done = 1;
            end else begin
              m_fill = m_walk ? 1 : WORDS;
            end
          end else if (!m_busy && start) begin
            m_cnt    = '0;
            m_walk   = (mode_i == 2'd1);
            m_cycles = cycles_i;
            if (seed_load) m_lcg = seed_i;
            if (cycles_i == '0) begin
              m_done = 1;
            end else begin
              m_busy = 1; m_done = 0;
              m_fill = m_walk ? 1 : WORDS;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit sl, input logic [31:0] sd, input logic [1:0] md,
                           input logic [31:0] cy);
    tick();
    start = 1'b1; seed_load = sl; seed_i = sd; mode_i = md; cycles_i = cy;
    tick();
    start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check(nm, 64'(out_valid), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    check(nm, 64'(done), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vec", 64'(out_vec), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_vec_count", 64'(vec_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Three LCG vectors from the reset seed; a start pulse mid-run must be ignored.
    start_run(1'b0, 32'd0, 2'd0, 32'd3);
    start = 1'b1; seed_load = 1'b1; seed_i = 32'd5; cycles_i = 32'd0;
    tick();
    start = 1'b0; seed_load = 1'b0;
    wait_done("t2_done");
    check("t2_count", 64'(vec_count), 64'd3);

    // Seed 0, single vector: first draw 0x3039, second draw low byte 0x7E.
    start_run(1'b1, 32'd0, 2'd0, 32'd1);
    check("t1_lat1", 64'(out_valid), 64'd0);
    tick();
    check("t1_lat2", 64'(out_valid), 64'd0);
    tick();
    check("t1_lat3", 64'(out_valid), 64'd1);
    check("t1_word0", 64'(out_vec[31:0]), 64'h3039);
    check("t1_word1", 64'(out_vec[39:32]), 64'h7E);
    tick();
    check("t1_done", 64'(done), 64'd1);
    check("t1_count", 64'(vec_count), 64'd1);

    // Walking one across 42 vectors wraps past OUT_W; last vector is bit 1.
    start_run(1'b0, 32'd0, 2'd1, 32'd42);
    wait_done("t3_done");
    check("t3_last_vec", 64'(out_vec), 64'h2);
    check("t3_count", 64'(vec_count), 64'd42);

    // Back-pressure in reserved mode 3 (behaves as LCG).
    out_ready = 1'b0;
    start_run(1'b0, 32'd0, 2'd3, 32'd2);
    wait_valid("t4_valid");
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_count", 64'(vec_count), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("t4_accept", 64'(vec_count), 64'd1);
    wait_done("t4_done");

    // Abort after one fill advance, then continue the sequence without reseeding.
    start_run(1'b0, 32'd0, 2'd0, 32'd5);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    start_run(1'b0, 32'd0, 2'd0, 32'd2);
    wait_done("t5_run_done");

    // Zero-length run goes straight to done.
    start_run(1'b0, 32'd0, 2'd0, 32'd0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    repeat (4) tick();

    // Asynchronous reset while a vector is on display.
    out_ready = 1'b0;
    start_run(1'b0, 32'd0, 2'd0, 32'd3);
    wait_valid("t7_valid");
    rst_n = 1'b0;
    #1;
    check("t7_out_vec", 64'(out_vec), 64'd0);
    check("t7_out_valid", 64'(out_valid), 64'd0);
    check("t7_vec_count", 64'(vec_count), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    start_run(1'b0, 32'd0, 2'd0, 32'd1);
    wait_done("t7_run_done");
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
